// File: rtl/sensor_poll_pkg.sv
// Shared types and sizing helpers for the sensor poll scheduler and its prescaler.
// No logic; latency and backpressure are not applicable.
package sensor_poll_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_DONE,
        S_NEXT,
        S_WAIT_PERIOD
    } state_e;

    function automatic int calc_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

    // Width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Free-running prescaler: registered one-cycle tick in the cycle the count equals DIV-1.
// Output is registered; there is no backpressure and the counter never stalls.
module ms_tick_gen
    import sensor_poll_pkg::*;
#(
    parameter int DIV = 50000
) (
    input  logic clk_in,
    input  logic rst_n,
    output logic tick_o
);

    localparam int W = cnt_w(DIV);

    logic [W-1:0] cnt_q, cnt_d;
    logic         tick_q, tick_d;

    always_comb begin
        cnt_d = cnt_q + W'(1);
        if (cnt_q == W'(DIV - 1)) begin
            cnt_d = '0;
        end
        tick_d = (cnt_d == W'(DIV - 1));
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/sensor_poll_scheduler.sv
// Round-robin poller: one-cycle start per channel, waits for done or tick-based timeout.
// All outputs registered; start follows enable by one cycle; a channel done cannot be stalled.
module sensor_poll_scheduler
    import sensor_poll_pkg::*;
#(
    parameter int CLK_HZ        = 50000000,
    parameter int TICK_HZ       = 1000,
    parameter int N_CH          = 4,
    parameter int PERIOD_TICKS  = 250,
    parameter int TIMEOUT_TICKS = 20
) (
    input  logic                    clk_in,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [N_CH-1:0]         done_i,
    input  logic                    clear_flags,
    output logic [N_CH-1:0]         start_o,
    output logic [$clog2(N_CH)-1:0] ch_o,
    output logic                    busy,
    output logic                    round_done,
    output logic [N_CH-1:0]         timeout_flags,
    output logic                    tick_o
);

    localparam int DIV = calc_div(CLK_HZ, TICK_HZ);
    localparam int CW  = $clog2(N_CH);
    localparam int PW  = cnt_w(PERIOD_TICKS + 1);
    localparam int TW  = cnt_w(TIMEOUT_TICKS);

    state_e          state_q, state_d;
    logic [CW-1:0]   ch_q, ch_d;
    logic [PW-1:0]   per_q, per_d;
    logic [TW-1:0]   to_q, to_d;
    logic [N_CH-1:0] start_q, start_d;
    logic [N_CH-1:0] flags_q, flags_d;
    logic [N_CH-1:0] set_mask;
    logic            busy_q, busy_d;
    logic            rd_q, rd_d;
    logic            tick;

    ms_tick_gen #(.DIV(DIV)) u_tick (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .tick_o (tick)
    );

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        per_d    = per_q;
        to_d     = to_q;
        set_mask = '0;
        rd_d     = 1'b0;

        if (tick && (state_q != S_IDLE) && (per_q != PW'(PERIOD_TICKS))) begin
            per_d = per_q + PW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_START;
                    ch_d    = '0;
                    per_d   = '0;
                end
            end
            S_START: begin
                to_d    = '0;
                state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                // Done takes priority over a coincident final timeout tick.
                if (done_i[ch_q]) begin
                    state_d = S_NEXT;
                end else if (tick) begin
                    if (to_q == TW'(TIMEOUT_TICKS - 1)) begin
                        set_mask[ch_q] = 1'b1;
                        state_d        = S_NEXT;
                    end else begin
                        to_d = to_q + TW'(1);
                    end
                end
            end
            S_NEXT: begin
                if (ch_q == CW'(N_CH - 1)) begin
                    rd_d    = 1'b1;
                    ch_d    = '0;
                    state_d = S_WAIT_PERIOD;
                end else begin
                    ch_d    = ch_q + CW'(1);
                    state_d = S_START;
                end
            end
            S_WAIT_PERIOD: begin
                if (per_q >= PW'(PERIOD_TICKS)) begin
                    per_d   = '0;
                    ch_d    = '0;
                    state_d = S_START;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Dropping enable aborts the round silently: no start, flag or round_done.
        if ((state_q != S_IDLE) && !enable) begin
            state_d  = S_IDLE;
            ch_d     = '0;
            set_mask = '0;
            rd_d     = 1'b0;
        end

        flags_d = (clear_flags ? '0 : flags_q) | set_mask;

        start_d = '0;
        if (state_d == S_START) begin
            start_d[ch_d] = 1'b1;
        end
        busy_d = (state_d == S_START) || (state_d == S_WAIT_DONE) || (state_d == S_NEXT);
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ch_q    <= '0;
            per_q   <= '0;
            to_q    <= '0;
            start_q <= '0;
            flags_q <= '0;
            busy_q  <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            per_q   <= per_d;
            to_q    <= to_d;
            start_q <= start_d;
            flags_q <= flags_d;
            busy_q  <= busy_d;
            rd_q    <= rd_d;
        end
    end

    assign start_o       = start_q;
    assign ch_o          = ch_q;
    assign busy          = busy_q;
    assign round_done    = rd_q;
    assign timeout_flags = flags_q;
    assign tick_o        = tick;

endmodule

// File: tb/tb_sensor_poll_scheduler.sv
// Directed bench: DIV=10, four channels, 5-tick period, 3-tick timeout.
module tb_sensor_poll_scheduler;

    logic       clk_in = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [3:0] done_i;
    logic       clear_flags;
    logic [3:0] start_o;
    logic [1:0] ch_o;
    logic       busy;
    logic       round_done;
    logic [3:0] timeout_flags;
    logic       tick_o;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    sensor_poll_scheduler #(
        .CLK_HZ(1000), .TICK_HZ(100), .N_CH(4), .PERIOD_TICKS(5), .TIMEOUT_TICKS(3)
    ) dut (
        .clk_in        (clk_in),
        .rst_n         (rst_n),
        .enable        (enable),
        .done_i        (done_i),
        .clear_flags   (clear_flags),
        .start_o       (start_o),
        .ch_o          (ch_o),
        .busy          (busy),
        .round_done    (round_done),
        .timeout_flags (timeout_flags),
        .tick_o        (tick_o)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic       en;
        logic [3:0] done;
        logic [3:0] exp_start;
        logic [1:0] exp_ch;
        logic       exp_busy;
        logic       exp_rd;
    } vec_t;

    vec_t tbl [19];

    function automatic vec_t mk(input logic en, input logic [3:0] done, input logic [3:0] st,
                                input logic [1:0] ch, input logic bz, input logic rd);
        vec_t v;
        v.en = en; v.done = done; v.exp_start = st; v.exp_ch = ch; v.exp_busy = bz; v.exp_rd = rd;
        return v;
    endfunction

    task automatic step();
        @(posedge clk_in);
        #1;
        cyc++;
    endtask

    task automatic goto(input int at);
        while (cyc < at) step();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".start"}, 32'(start_o), 32'h0);
        chk({tag, ".ch"}, 32'(ch_o), 32'h0);
        chk({tag, ".busy"}, 32'(busy), 32'h0);
        chk({tag, ".round_done"}, 32'(round_done), 32'h0);
    endtask

    task automatic pulse_done(input int at, input logic [3:0] m);
        goto(at);
        done_i = m;
        step();
        done_i = '0;
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; done_i = '0; clear_flags = 1'b0;

        // One full round, done answered two cycles after each start (cycles 20..38).
        tbl[0]  = mk(1, 4'h0, 4'h0, 2'd0, 0, 0);
        tbl[1]  = mk(1, 4'h0, 4'h1, 2'd0, 1, 0);
        tbl[2]  = mk(1, 4'h0, 4'h0, 2'd0, 1, 0);
        tbl[3]  = mk(1, 4'h1, 4'h0, 2'd0, 1, 0);
        tbl[4]  = mk(1, 4'h0, 4'h0, 2'd0, 1, 0);
        tbl[5]  = mk(1, 4'h0, 4'h2, 2'd1, 1, 0);
        tbl[6]  = mk(1, 4'h0, 4'h0, 2'd1, 1, 0);
        tbl[7]  = mk(1, 4'h2, 4'h0, 2'd1, 1, 0);
        tbl[8]  = mk(1, 4'h0, 4'h0, 2'd1, 1, 0);
        tbl[9]  = mk(1, 4'h0, 4'h4, 2'd2, 1, 0);
        tbl[10] = mk(1, 4'h0, 4'h0, 2'd2, 1, 0);
        tbl[11] = mk(1, 4'h4, 4'h0, 2'd2, 1, 0);
        tbl[12] = mk(1, 4'h0, 4'h0, 2'd2, 1, 0);
        tbl[13] = mk(1, 4'h0, 4'h8, 2'd3, 1, 0);
        tbl[14] = mk(1, 4'h0, 4'h0, 2'd3, 1, 0);
        tbl[15] = mk(1, 4'h8, 4'h0, 2'd3, 1, 0);
        tbl[16] = mk(1, 4'h0, 4'h0, 2'd3, 1, 0);
        tbl[17] = mk(1, 4'h0, 4'h0, 2'd0, 0, 1);
        tbl[18] = mk(1, 4'h0, 4'h0, 2'd0, 0, 0);

        repeat (5) @(posedge clk_in);
        #1;
        rst_n = 1'b1;
        cyc   = 0;

        // Idle after reset: everything quiet, tick every 10 cycles starting at cycle 9.
        for (int c = 0; c < 20; c++) begin
            chk_quiet("idle");
            chk("idle.flags", 32'(timeout_flags), 32'h0);
            chk("idle.tick", 32'(tick_o), 32'((cyc % 10) == 9));
            step();
        end

        for (int i = 0; i < 19; i++) begin
            chk("r1.tick", 32'(tick_o), 32'((cyc % 10) == 9));
            chk("r1.start", 32'(start_o), 32'(tbl[i].exp_start));
            chk("r1.ch", 32'(ch_o), 32'(tbl[i].exp_ch));
            chk("r1.busy", 32'(busy), 32'(tbl[i].exp_busy));
            chk("r1.round_done", 32'(round_done), 32'(tbl[i].exp_rd));
            chk("r1.flags", 32'(timeout_flags), 32'h0);
            enable = tbl[i].en;
            done_i = tbl[i].done;
            step();
        end
        done_i = '0;

        // Next round begins after five ticks counted from cycle 21.
        goto(70);
        chk("period.early", 32'(start_o), 32'h0);
        step();
        chk("period.start", 32'(start_o), 32'h1);

        // Round 2: channel 2 never answers and times out on the third tick.
        pulse_done(73, 4'h1);
        pulse_done(77, 4'h2);
        goto(79);
        chk("r2.start2", 32'(start_o), 32'h4);
        goto(109);
        chk("r2.pre_to_flags", 32'(timeout_flags), 32'h0);
        chk("r2.pre_to_busy", 32'(busy), 32'h1);
        step();
        chk("r2.to_flags", 32'(timeout_flags), 32'h4);
        chk("r2.to_start", 32'(start_o), 32'h0);
        step();
        chk("r2.start3", 32'(start_o), 32'h8);
        chk("r2.ch3", 32'(ch_o), 32'h3);
        pulse_done(113, 4'h8);
        goto(115);
        chk("r2.round_done", 32'(round_done), 32'h1);
        goto(121);
        chk("r3.start0", 32'(start_o), 32'h1);

        // Round 3: channel 1 times out while clear_flags pulses in the same cycle.
        pulse_done(123, 4'h1);
        goto(149);
        chk("r3.pre_flags", 32'(timeout_flags), 32'h4);
        clear_flags = 1'b1;
        step();
        clear_flags = 1'b0;
        chk("r3.set_beats_clear", 32'(timeout_flags), 32'h2);
        pulse_done(153, 4'h4);
        pulse_done(157, 4'h8);
        goto(171);
        chk("r4.start0", 32'(start_o), 32'h1);

        // Round 4: done arrives with the final timeout tick, so no flag is set.
        clear_flags = 1'b1;
        step();
        clear_flags = 1'b0;
        chk("r4.cleared", 32'(timeout_flags), 32'h0);
        pulse_done(173, 4'h1);
        pulse_done(177, 4'h2);
        pulse_done(209, 4'h4);
        chk("r4.done_wins_flags", 32'(timeout_flags), 32'h0);
        chk("r4.done_wins_busy", 32'(busy), 32'h1);
        step();
        chk("r4.start3", 32'(start_o), 32'h8);
        pulse_done(213, 4'h8);
        goto(221);
        chk("r5.start0", 32'(start_o), 32'h1);

        // Round 5: drop enable while waiting on channel 1, then re-enable and reset.
        pulse_done(223, 4'h1);
        goto(225);
        chk("r5.start1", 32'(start_o), 32'h2);
        goto(227);
        enable = 1'b0;
        step();
        chk_quiet("abort");
        step();
        chk_quiet("abort_hold");
        enable = 1'b1;
        step();
        chk("reen.start", 32'(start_o), 32'h1);
        chk("reen.busy", 32'(busy), 32'h1);
        goto(232);
        rst_n = 1'b0;
        step();
        chk_quiet("rst");
        chk("rst.tick", 32'(tick_o), 32'h0);
        chk("rst.flags", 32'(timeout_flags), 32'h0);
        rst_n = 1'b1;
        goto(241);
        chk("rst.tick_quiet", 32'(tick_o), 32'h0);
        step();
        chk("rst.tick_first", 32'(tick_o), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sensor_poll_scheduler.md
Name: sensor_poll_scheduler

Overview:
Round-robin scheduler that sequences polling of N_CH sensor front-ends from one system clock. An internal prescaler produces a 1 ms tick enable; no derived clocks are used. Once per poll period the block issues a one-cycle start pulse to each channel in turn, waits for that channel's done or a timeout, and records timeouts in sticky flags. It sits between the system clock domain and the sensor interface blocks.

Parameters:
CLK_HZ, 50000000, input clock frequency
TICK_HZ, 1000, tick rate; DIV = CLK_HZ/TICK_HZ, which must be an integer ≥ 2
N_CH, 4, number of polled channels, ≥ 2
PERIOD_TICKS, 250, ticks from one round start to the next
TIMEOUT_TICKS, 20, ticks allowed per channel for done, ≥ 1

Ports:
clk_in  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
enable  input  1  level; high lets rounds run
done_i  input  N_CH  per-channel completion, one-cycle pulse or level
clear_flags  input  1  one-cycle pulse; clears timeout_flags
start_o  output  N_CH  one-hot, one-cycle start pulse
ch_o  output  $clog2(N_CH)  channel currently being served
busy  output  1  high in START, WAIT_DONE and NEXT
round_done  output  1  one-cycle pulse at the end of each round
timeout_flags  output  N_CH  sticky; bit i is set when channel i times out
tick_o  output  1  one-cycle 1 ms tick enable

Behaviour:
- Reset (rst_n low at posedge clk_in) forces:
  - all outputs to 0
  - prescaler, period counter and timeout counter to 0
  - FSM to IDLE
- Prescaler:
  - counts 0..DIV-1 and wraps; tick_o = 1 in the cycle the count equals DIV-1
  - runs freely whatever enable or the FSM state is
- All outputs are registered.
- FSM states: IDLE, START, WAIT_DONE, NEXT, WAIT_PERIOD.
  - IDLE: when enable = 1, go to START with ch = 0 and clear the period counter.
  - START: lasts exactly one cycle. start_o[ch] = 1 and all other bits are 0. Clear the timeout counter and go to WAIT_DONE.
  - WAIT_DONE: done_i[ch] = 1 goes to NEXT. Otherwise, if tick_o = 1 and the timeout count equals TIMEOUT_TICKS-1, set timeout_flags[ch] and go to NEXT. Otherwise the timeout count increments on each tick. If done and timeout occur in the same cycle, done wins and no flag is set. done_i bits for other channels are ignored.
  - NEXT: if ch == N_CH-1, pulse round_done, set ch = 0 and go to WAIT_PERIOD. Otherwise ch = ch+1 and go to START.
  - WAIT_PERIOD: when period count ≥ PERIOD_TICKS, clear the period counter and go to START with ch = 0.
- Period counter:
  - increments on every tick while not in IDLE
  - saturates at PERIOD_TICKS
  - an overrunning round therefore starts the next round on the cycle after NEXT
- enable low in any non-IDLE state: next state is IDLE, ch = 0. No start pulse is issued and no flag is set in that transition cycle. round_done is not pulsed for the aborted round.
- timeout_flags:
  - cleared by clear_flags
  - a set and a clear in the same cycle on the same bit: set wins
  - unaffected by enable
- Latency: enable rising in IDLE at cycle k gives start_o[0] high in cycle k+1. A done in cycle m for a non-last channel gives the next start_o in cycle m+2.
- ch_o always reflects the internal ch register.

Decomposition:
- Package sensor_poll_pkg holds:
  - the FSM state enum (5 states, 3-bit encoding)
  - localparam function for DIV
  - counter width helpers ($clog2 of DIV, PERIOD_TICKS+1 and TIMEOUT_TICKS)
- Sub-module ms_tick_gen: the prescaler, with parameter DIV and ports clk_in, rst_n, tick_o. It is reused by other timer blocks.

Test Plan (bench params: CLK_HZ=1000, TICK_HZ=100 so DIV=10; N_CH=4, PERIOD_TICKS=5, TIMEOUT_TICKS=3):
1. Reset held for 5 cycles, then released with enable=0 -> all outputs stay 0; tick_o pulses every 10 cycles, first at cycle 9 after release.
2. Raise enable; the bench answers done_i[ch] 2 cycles after each start -> start_o sequence 0001, 0010, 0100, 1000 with 3 cycles between starts; round_done once; the next round's start_o=0001 follows 5 ticks after the round start.
3. Never assert done_i[2] -> timeout_flags=0100 after 3 ticks in WAIT_DONE for ch 2; start_o=1000 follows 2 cycles later.
4. done_i[2] in the same cycle as the final timeout tick -> timeout_flags stays 0000.
5. clear_flags pulsed in the same cycle that ch 1 times out, with flags at 0100 -> flags become 0010.
6. Deassert enable in WAIT_DONE for ch 1 -> next cycle IDLE, ch_o=0, busy=0, no round_done. Re-enable -> start_o=0001 the following cycle. Assert reset mid-round -> everything returns to 0.
